dmem_pipe: RTL



---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_if.sv | 29 ++
 rtl/dmem_resp_pipe.sv | 45 ++++
 rtl/dmem_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and width helpers for the dmem_pipe slice.
// Holds the clear/run FSM encoding, byte-lane helpers and response error causes.
package dmem_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    // Why a response was flagged; carried down the response pipe.
    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_ALIGN  = 2'd1,
        ERR_RANGE  = 2'd2,
        ERR_PARITY = 2'd3
    } err_e;

    localparam int ERR_W = 2;

    // BE_W = DATA_W/8 byte lanes per word.
    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

    // OFF_W = log2(BE_W) byte-offset bits below the word index.
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bus between the load/store path and dmem_pipe.
// master drives req_*; slave (the memory) drives req_ready and resp_*.
interface dmem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_resp_pipe.sv
// dmem_resp_pipe: LAT-deep shift of {valid, err, data} with synchronous flush.
// Ports: clock, flush_i, valid_i/err_i/data_i in, valid_o/err_o/data_o out.
module dmem_resp_pipe #(
    parameter int DATA_W = 32,
    parameter int ERR_W  = 2,
    parameter int LAT    = 2
) (
    input  logic              clock,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [ERR_W-1:0]  err_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [ERR_W-1:0]  err_o,
    output logic [DATA_W-1:0] data_o
);

    logic [LAT-1:0]    vld_q;
    logic [ERR_W-1:0]  err_q [LAT];
    logic [DATA_W-1:0] dat_q [LAT];

    always_ff @(posedge clock) begin
        if (flush_i) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                err_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            err_q[0] <= err_i;
            dat_q[0] <= data_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[LAT-1];
    assign err_o   = err_q[LAT-1];
    assign data_o  = dat_q[LAT-1];

endmodule

// File: rtl/dmem_pipe.sv
// dmem_pipe: word RAM with byte enables, fixed-latency in-order responses,
// alignment/range error reporting and optional clear-after-reset.
// Ports: clock, reset (sync, active-high), bus (dmem_if.slave: req_valid/
// req_ready/req_write/req_addr/req_wdata/req_be, resp_valid/resp_rdata/
// resp_err), init_done (clear finished). With DMEM_PARITY_EN defined a
// per-byte even-parity array is kept and parity_err (sticky) is added.
// DATA_W must be at least 16 so a byte offset exists.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 16,
    parameter int DEPTH          = 1024,
    parameter int RD_LAT         = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic   clock,
    input  logic   reset,
    dmem_if.slave  bus,
    output logic   init_done
`ifdef DMEM_PARITY_EN
    ,
    output logic   parity_err
`endif
);

    localparam int BE_W   = be_w(DATA_W);
    localparam int OFF_W  = off_w(DATA_W);
    localparam int WIDX_W = ADDR_W - OFF_W;
    localparam int IDX_W  = $clog2(DEPTH);

    // Backdoor-visible storage.
    logic [DATA_W-1:0] mcell [0:DEPTH-1];

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;

    logic               accept;
    logic               clr_we;
    logic               wr_en;
    logic               misalign;
    logic               range_bad;
    logic [WIDX_W-1:0]  widx;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  rd_word;
    err_e               s0_cause;
    logic               s0_valid;
    logic [ERR_W-1:0]   s0_err;
    logic [DATA_W-1:0]  s0_data;
    logic [ERR_W-1:0]   resp_cause;

    // Clear/run sequencer.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d   = S_RUN;
                    clr_idx_d = '0;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign init_done     = (state_q == S_RUN);
    assign bus.req_ready = init_done && !reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign clr_we        = (state_q == S_CLEAR) && !reset;

    // Address decode.
    assign widx      = bus.req_addr[ADDR_W-1:OFF_W];
    assign idx       = widx[IDX_W-1:0];
    assign misalign  = |bus.req_addr[OFF_W-1:0];
    assign range_bad = ({1'b0, widx} >= (WIDX_W + 1)'(DEPTH));
    assign rd_word   = mcell[idx];

`ifdef DMEM_PARITY_EN
    logic [BE_W-1:0] mpar [0:DEPTH-1];
    logic [BE_W-1:0] rd_par;
    logic [BE_W-1:0] wr_par;
    logic            par_bad;
    logic            par_hit;
    logic            par_err_q;

    always_comb begin
        rd_par = '0;
        wr_par = '0;
        for (int b = 0; b < BE_W; b++) begin
            rd_par[b] = ^rd_word[b*8 +: 8];
            wr_par[b] = ^bus.req_wdata[b*8 +: 8];
        end
    end

    assign par_bad = |(rd_par ^ mpar[idx]);
`endif

    // Address errors win over parity; parity only qualifies clean reads.
    always_comb begin
        s0_cause = ERR_NONE;
        unique case (1'b1)
            misalign:                s0_cause = ERR_ALIGN;
            (!misalign && range_bad): s0_cause = ERR_RANGE;
`ifdef DMEM_PARITY_EN
            (!misalign && !range_bad && !bus.req_write && par_bad):
                                     s0_cause = ERR_PARITY;
`endif
            default:                 s0_cause = ERR_NONE;
        endcase
    end

    assign wr_en    = accept && bus.req_write && !misalign && !range_bad;
    assign s0_valid = accept;
    assign s0_err   = accept ? s0_cause : ERR_NONE;
    // Parity-flagged reads still return the stored word.
    assign s0_data  = (accept && !bus.req_write && !misalign && !range_bad)
                    ? rd_word : '0;

    // Array update: clear sweep or lane-masked write, never both.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mcell[clr_idx_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.req_be[b]) begin
                    mcell[idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
                end
            end
        end
    end

`ifdef DMEM_PARITY_EN
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mpar[clr_idx_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.req_be[b]) begin
                    mpar[idx][b] <= wr_par[b];
                end
            end
        end
    end
`endif

    dmem_resp_pipe #(
        .DATA_W (DATA_W),
        .ERR_W  (ERR_W),
        .LAT    (RD_LAT)
    ) u_resp (
        .clock   (clock),
        .flush_i (reset),
        .valid_i (s0_valid),
        .err_i   (s0_err),
        .data_i  (s0_data),
        .valid_o (bus.resp_valid),
        .err_o   (resp_cause),
        .data_o  (bus.resp_rdata)
    );

    assign bus.resp_err = (resp_cause != ERR_NONE);

`ifdef DMEM_PARITY_EN
    // High in the same cycle as the first mismatching response.
    assign par_hit = bus.resp_valid && (resp_cause == ERR_PARITY);

    always_ff @(posedge clock) begin
        if (reset) begin
            par_err_q <= 1'b0;
        end else if (par_hit) begin
            par_err_q <= 1'b1;
        end
    end

    assign parity_err = par_err_q | par_hit;
`endif

endmodule
